// File: rtl/bship_pkg.sv
// Shared phase codes, board defaults and score helpers for the battleship controller.
package bship_pkg;

    localparam int GRID_DEF  = 10;
    localparam int POS_W_DEF = 4;

    localparam logic [2:0] PH_CLEAR  = 3'd0;
    localparam logic [2:0] PH_IDLE   = 3'd1;
    localparam logic [2:0] PH_PLAY   = 3'd2;
    localparam logic [2:0] PH_FIRE   = 3'd3;
    localparam logic [2:0] PH_SETTLE = 3'd4;
    localparam logic [2:0] PH_OVER   = 3'd5;

    localparam int                   SCORE_W   = 4;
    localparam logic [SCORE_W-1:0]   SCORE_MAX = 4'd15;

    typedef struct packed {
        logic u;
        logic d;
        logic l;
        logic r;
    } dir_t;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (v == SCORE_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/bship_repeat.sv
// Direction auto-repeat: one-cycle move on a new direction, then after REPEAT_DELAY and every REPEAT_RATE.
// move is combinational from registered hold state; no backpressure, counter runs in every phase.
module bship_repeat #(
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 10000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] dir,
    output logic       move
);

    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CW       = $clog2(HOLD_MAX + 1);
    localparam logic [CW-1:0] DELAY_C = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] RATE_C  = CW'(REPEAT_RATE);

    logic [3:0]    dir_q;
    logic [CW-1:0] hold;
    logic          repeating;
    logic          changed;
    logic          due;

    always_comb begin
        changed = (dir != 4'd0) && (dir != dir_q);
        due     = (dir != 4'd0) && !changed && (hold == (repeating ? RATE_C : DELAY_C));
        move    = changed || due;
    end

    // hold counts cycles since the last event, so it reloads to 1 on every event
    always_ff @(posedge clk) begin
        if (!reset) begin
            dir_q     <= 4'd0;
            hold      <= '0;
            repeating <= 1'b0;
        end else begin
            dir_q <= dir;
            if (dir == 4'd0) begin
                hold      <= '0;
                repeating <= 1'b0;
            end else if (move) begin
                hold      <= CW'(1);
                repeating <= due;
            end else begin
                hold <= hold + 1'b1;
            end
        end
    end

endmodule

// File: rtl/battleship_ctrl.sv
// Battleship round sequencer, cursor and tallies; all outputs registered, one-cycle bomb/clear pulses.
// Optional BSHIP_AUTO_RESTART_EN: OVER returns to CLEAR after OVER_TIMEOUT cycles without a press.
module battleship_ctrl
    import bship_pkg::*;
#(
    parameter int GRID          = GRID_DEF,
    parameter int POS_W         = POS_W_DEF,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_RATE   = 10000000,
    parameter int CLEAR_CYCLES  = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int OVER_TIMEOUT  = 300000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_u,
    input  logic               btn_d,
    input  logic               btn_l,
    input  logic               btn_r,
    input  logic               btn_c,
    input  logic               win,
    input  logic               lose,
    output logic [POS_W-1:0]   sprite_row,
    output logic [POS_W-1:0]   sprite_col,
    output logic               bomb,
    output logic               game_clear,
    output logic [2:0]         phase,
    output logic [SCORE_W-1:0] wins,
    output logic [SCORE_W-1:0] losses
);

    localparam logic [POS_W-1:0] POS_MAX = POS_W'(GRID - 1);
    localparam int CNT_MAX = (CLEAR_CYCLES > SETTLE_CYCLES) ? CLEAR_CYCLES : SETTLE_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] CLEAR_LAST  = CW'(CLEAR_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

    dir_t             dir;
    logic             move;
    logic             btn_c_q;
    logic             c_edge;
    logic [CW-1:0]    cnt;
    logic [POS_W-1:0] row_mv;
    logic [POS_W-1:0] col_mv;

`ifdef BSHIP_AUTO_RESTART_EN
    localparam int TW = $clog2(OVER_TIMEOUT + 1);
    localparam logic [TW-1:0] OVER_LAST = TW'(OVER_TIMEOUT - 1);
    logic [TW-1:0] over_tmr;
`endif

    assign dir    = {btn_u, btn_d, btn_l, btn_r};
    assign c_edge = btn_c && !btn_c_q;

    bship_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_repeat (
        .clk   (clk),
        .reset (reset),
        .dir   (dir),
        .move  (move)
    );

    // opposing buttons on one axis cancel; each axis wraps independently
    always_comb begin
        row_mv = sprite_row;
        col_mv = sprite_col;
        if (dir.u && !dir.d)
            row_mv = (sprite_row == '0) ? POS_MAX : sprite_row - 1'b1;
        else if (dir.d && !dir.u)
            row_mv = (sprite_row == POS_MAX) ? '0 : sprite_row + 1'b1;
        if (dir.l && !dir.r)
            col_mv = (sprite_col == '0) ? POS_MAX : sprite_col - 1'b1;
        else if (dir.r && !dir.l)
            col_mv = (sprite_col == POS_MAX) ? '0 : sprite_col + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            phase      <= PH_CLEAR;
            cnt        <= '0;
            sprite_row <= '0;
            sprite_col <= '0;
            bomb       <= 1'b0;
            game_clear <= 1'b1;
            wins       <= '0;
            losses     <= '0;
            btn_c_q    <= 1'b1;
`ifdef BSHIP_AUTO_RESTART_EN
            over_tmr   <= '0;
`endif
        end else begin
            btn_c_q <= btn_c;
            bomb    <= 1'b0;
            case (phase)
                PH_CLEAR: begin
                    if (cnt == CLEAR_LAST) begin
                        phase      <= PH_IDLE;
                        cnt        <= '0;
                        game_clear <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PH_IDLE: begin
                    if (c_edge) begin
                        phase      <= PH_PLAY;
                        sprite_row <= '0;
                        sprite_col <= '0;
                    end
                end
                PH_PLAY: begin
                    if (win || lose) begin
                        phase <= PH_OVER;
                        if (win) wins   <= sat_inc(wins);
                        else     losses <= sat_inc(losses);
`ifdef BSHIP_AUTO_RESTART_EN
                        over_tmr <= '0;
`endif
                    end else if (c_edge) begin
                        phase <= PH_FIRE;
                        bomb  <= 1'b1;
                    end else if (move) begin
                        sprite_row <= row_mv;
                        sprite_col <= col_mv;
                    end
                end
                PH_FIRE: begin
                    phase <= PH_SETTLE;
                    cnt   <= '0;
                end
                PH_SETTLE: begin
                    if (cnt == SETTLE_LAST) phase <= PH_PLAY;
                    else                    cnt   <= cnt + 1'b1;
                end
                PH_OVER: begin
                    if (c_edge) begin
                        phase      <= PH_CLEAR;
                        cnt        <= '0;
                        game_clear <= 1'b1;
                    end
`ifdef BSHIP_AUTO_RESTART_EN
                    else if (over_tmr == OVER_LAST) begin
                        phase      <= PH_CLEAR;
                        cnt        <= '0;
                        game_clear <= 1'b1;
                    end else begin
                        over_tmr <= over_tmr + 1'b1;
                    end
`endif
                end
                default: begin
                    phase      <= PH_CLEAR;
                    cnt        <= '0;
                    game_clear <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/battleship_ctrl.md
Name: battleship_ctrl

Overview:
- Round sequencer and cursor controller for the battleship board-state block.
- Takes the synchronized push buttons and moves the target cursor, with wrap-around and auto-repeat.
- Issues single-cycle bomb pulses and a clear pulse to the board block, and sequences title → play → game-over → clear.
- Keeps saturating win/loss tallies for the display.

Parameters:
- GRID, 10, board edge length in cells; cursor range 0..GRID-1.
- POS_W, 4, width of the row/col buses; must satisfy 2^POS_W >= GRID.
- REPEAT_DELAY, 25000000, cycles a direction is held before the first auto-repeat.
- REPEAT_RATE, 10000000, cycles between later auto-repeats.
- CLEAR_CYCLES, 4, cycles game_clear is held high.
- SETTLE_CYCLES, 2, cycles waited after a bomb before win/lose are sampled.
- OVER_TIMEOUT, 300000000, cycles in OVER before auto restart (AUTO_RESTART_EN only).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- btn_u/btn_d/btn_l/btn_r  in  1 each  direction buttons; levels, already synchronized/debounced.
- btn_c  in  1  fire/start button level.
- win  in  1  board block win flag.
- lose  in  1  board block lose flag.
- sprite_row  out  POS_W  cursor row.
- sprite_col  out  POS_W  cursor column.
- bomb  out  1  one-cycle fire pulse to board block.
- game_clear  out  1  active-high clear to board block reset.
- phase  out  3  state code: CLEAR=0, IDLE=1, PLAY=2, FIRE=3, SETTLE=4, OVER=5.
- wins  out  4  completed wins, saturating.
- losses  out  4  completed losses, saturating.

Behaviour:
- All outputs are registered.
- Reset (reset==0 at a clk edge): state CLEAR, cnt=0, row=col=0, bomb=0, game_clear=1, wins=losses=0.
- Edge detect: btn_c edge = btn_c & ~btn_c_q. btn_c_q resets to 1, so a button held through reset is not a press.
- CLEAR state:
  - game_clear=1.
  - cnt counts 0..CLEAR_CYCLES-1, then next=IDLE and game_clear=0 on that transition.
- IDLE state: btn_c edge → PLAY; row=col=0 on entry.
- PLAY state:
  - win or lose high → OVER. This takes priority over a btn_c edge in the same cycle.
  - Else btn_c edge → FIRE. The cursor is frozen at its current value, and any same-cycle move is dropped.
  - Else cursor move events apply.
- FIRE state: bomb=1 for exactly this one cycle, then SETTLE with cnt=0.
- SETTLE state:
  - Waits SETTLE_CYCLES cycles, then → PLAY.
  - btn_c edges and moves are ignored here. The cycle after any FIRE is always bomb=0.
- OVER state:
  - On entry, wins += win or losses += lose. Each saturates at 15. If both are high, count the win only.
  - btn_c edge → CLEAR; the following IDLE needs another press to start.
- Move events:
  - dir = {u,d,l,r}. An event fires when dir is nonzero and differs from dir_q.
  - While dir is nonzero and unchanged, the hold counter fires at REPEAT_DELAY, then every REPEAT_RATE after that.
  - Any change in dir restarts the hold counter. dir==0 clears it.
  - The counter width holds max(REPEAT_DELAY, REPEAT_RATE).
- Move arithmetic:
  - u: row-1, wrapping 0→GRID-1. d: row+1, wrapping GRID-1→0.
  - l/r: same rule on col.
  - u&d together: no row change. l&r together: no col change. Diagonals move both axes.
  - Moves take effect only in PLAY. Hold counters keep running in every state.
- Reset asserted mid-operation (e.g. during FIRE): bomb drops in the next cycle, and game_clear=1 in the same cycle.

Optional Feature:
- Macro: BSHIP_AUTO_RESTART_EN.
- Defined: an OVER timer counts in OVER. At OVER_TIMEOUT-1 the state → CLEAR, unless a btn_c edge got there first.
- Not defined: OVER exits only on a btn_c edge. The timer logic is absent.

Decomposition:
- Package bship_pkg:
  - phase localparams (codes 0..5).
  - GRID and POS_W defaults.
  - Score width 4 and the saturation max 15.
- Sub-module: bship_repeat. It covers the dir register, hold counter and single-cycle move-event generation, with the REPEAT_DELAY and REPEAT_RATE parameters.
- The top level holds the FSM, cursor, tallies and optional timer.

Test Plan (REPEAT_DELAY=5, REPEAT_RATE=3, CLEAR_CYCLES=4, SETTLE_CYCLES=2, OVER_TIMEOUT=20):
- Reset low 3 cycles, then high → game_clear=1 for 4 cycles after release, phase=1, then 0,0 cursor; wins=losses=0.
- btn_c pulse in IDLE → phase=2. Tap btn_u once → row=9. Tap btn_l → col=9. Tap btn_d → row=0.
- Hold btn_r 14 cycles in PLAY from col 0 → events at cycles 0, 5, 8, 11 → col=4; btn_l+btn_r held → col unchanged.
- btn_c edge at (3,4) → bomb high exactly 1 cycle, phase 3→4→4→2. Second btn_c during SETTLE produces no bomb.
- Raise lose in PLAY → phase=5 next cycle, losses=1. Repeat 16 rounds → losses stays 15.
- With BSHIP_AUTO_RESTART_EN, win high → OVER, then after 20 cycles phase=0. Without the macro, phase stays 5 until btn_c.
